fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer driving the 6-bit program counter and instruction register.
//  Runs the FETCH/DECODE/EXEC loop and owns the next-address register. Drives the counter's branch/target inputs so the PC moves only during FETCH.
//  Accepts branch, stall and halt requests from the decode/ALU logic; counts retired instructions.
// PARAMETERS
//  ADDR_W     6    PC / ROM address width (64 locations)
//  CNT_W      16   retired-instruction counter width
//  STACK_D    4    return-stack depth (CALL_STACK_EN only)
// PORTS
//  clk         in   1        clock; sequencer updates on posedge, PC samples outputs on negedge
//  rst         in   1        reset, synchronous, active-high
//  run         in   1        start/resume request (level)
//  stall       in   1        hold EXEC this cycle
//  halt_req    in   1        stop after current EXEC
//  br_req      in   1        branch taken, valid in EXEC only
//  br_target   in   ADDR_W   branch destination
//  pc_branch   out  1        to PC branch input
//  pc_target   out  ADDR_W   to PC pc_in
//  ir_load     out  1        IR capture strobe, 1 cycle in FETCH
//  state       out  2        current state encoding
//  halted      out  1        high in HALT
//  retired     out  CNT_W    instructions completed, saturating
// BEHAVIOUR
//  States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=3'b? -> use 3-bit internal; state port = {HALT ? 2'b00 : enc} with halted flag.
//  Reset (any state, mid-instruction included): state=IDLE, next_addr=0, retired=0, ir_load=0, halted=0, pc_branch=1, pc_target=0.
//  pc_target = next_addr always; pc_branch = (state != FETCH). Non-FETCH states re-load next_addr, freezing the PC.
//  IDLE: run=1 -> FETCH; else stay.
//  FETCH: ir_load=1; next_addr <= next_addr+1 mod 2^ADDR_W (63 -> 0, no flag); -> DECODE. Exactly 1 cycle.
//  DECODE: -> EXEC. Exactly 1 cycle; requests ignored.
//  EXEC, priority high->low: stall (hold EXEC, nothing retires) > halt_req (retire, -> HALT, br_req discarded)
//    > br_req (next_addr <= br_target, retire, -> FETCH) > plain retire, -> FETCH.
//  Minimum instruction latency 3 cycles; each stall cycle adds 1.
//  HALT: halted=1; next_addr frozen; run=1 with halt_req=0 -> FETCH, continuing at next_addr.
//  retired increments by 1 per retire, saturates at 2^CNT_W-1.
//  br_req/stall/halt_req outside EXEC: no effect.
// CONFIGURATION
//  FETCH_CALL_STACK_EN defined: adds inputs call_req and ret_req, plus output stack_err.
//    These requests are evaluated in EXEC at the same priority slot as br_req; call_req wins over ret_req.
//    call_req pushes next_addr and jumps to br_target. ret_req pops into next_addr.
//    Push when full or pop when empty: no stack change, plain retire, stack_err sticky until rst.
//  FETCH_CALL_STACK_EN undefined: no ports, no stack logic; behaviour exactly as above.
// STRUCTURE
//  Shared package fetch_pkg: state enum type, ADDR_W default, reset-vector constant (0).
//  One sub-module, ret_stack: LIFO of STACK_D x ADDR_W with push/pop/full/empty. Instantiated only under the macro.
// TESTING
//  rst, run=1 for 9 cycles -> ir_load pulses at cycles 1,4,7; pc_target 1,2,3; retired=3.
//  Branch: EXEC with br_req=1, br_target=6'd40 -> next FETCH pc_branch=0, following IR addr 40; next_addr=41.
//  Wrap: branch to 63 then run -> after FETCH next_addr=0, no error.
//  Stall 4 cycles in EXEC, then halt_req+br_req -> HALT; next_addr unchanged; retired +1; run resumes at same addr.
//  rst asserted in DECODE -> next cycle IDLE, pc_target=0, retired=0.
//  FETCH_CALL_STACK_EN: 5 calls with STACK_D=4 -> 5th sets stack_err; 4 rets return in LIFO order.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
// The optional call/return stack is enabled by defining FETCH_CALL_STACK_EN.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 6;
    localparam logic [FETCH_ADDR_W-1:0] RESET_VEC = '0;

    // HALT needs a fifth code; it is folded to 2'b00 on the external state port.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Request/control bundle between the sequencer and the decode/ALU/PC logic.
// Call/return signals exist only when FETCH_CALL_STACK_EN is defined.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned CNT_W  = 16
);
    logic              run;
    logic              stall;
    logic              halt_req;
    logic              br_req;
    logic [ADDR_W-1:0] br_target;
    logic              pc_branch;
    logic [ADDR_W-1:0] pc_target;
    logic              ir_load;
    logic [1:0]        state;
    logic              halted;
    logic [CNT_W-1:0]  retired;
`ifdef FETCH_CALL_STACK_EN
    logic              call_req;
    logic              ret_req;
    logic              stack_err;
`endif

    modport master (
        input  run, stall, halt_req, br_req, br_target,
`ifdef FETCH_CALL_STACK_EN
        input  call_req, ret_req,
        output stack_err,
`endif
        output pc_branch, pc_target, ir_load, state, halted, retired
    );

    modport slave (
        output run, stall, halt_req, br_req, br_target,
`ifdef FETCH_CALL_STACK_EN
        output call_req, ret_req,
        input  stack_err,
`endif
        input  pc_branch, pc_target, ir_load, state, halted, retired
    );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO for the fetch sequencer; push/pop are ignored when full/empty.
// Only instantiated when FETCH_CALL_STACK_EN is defined.
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push && !full) begin
            mem_d[cnt_q[IDX_W-1:0]] = din;
            cnt_d = cnt_q + PTR_W'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - PTR_W'(1);
        end
    end

    always_comb begin
        full  = (cnt_q == PTR_W'(DEPTH));
        empty = (cnt_q == '0);
        top   = mem_q[IDX_W'(cnt_q - PTR_W'(1))];
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// FETCH/DECODE/EXEC sequencer owning the next-address register and retire counter.
// FETCH_CALL_STACK_EN adds call/return requests backed by ret_stack.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned CNT_W  = 16
`ifdef FETCH_CALL_STACK_EN
    ,
    parameter int unsigned STACK_D = 4
`endif
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.master bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire;

`ifdef FETCH_CALL_STACK_EN
    logic              push, pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;
    logic              stack_err_q, stack_err_d;

    // In EXEC next_addr_q already points past the current instruction: the return address.
    ret_stack #(.DEPTH(STACK_D), .WIDTH(ADDR_W)) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (next_addr_q),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            next_addr_q <= ADDR_W'(RESET_VEC);
            retired_q   <= '0;
`ifdef FETCH_CALL_STACK_EN
            stack_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            retired_q   <= retired_d;
`ifdef FETCH_CALL_STACK_EN
            stack_err_q <= stack_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        retire      = 1'b0;
`ifdef FETCH_CALL_STACK_EN
        push        = 1'b0;
        pop         = 1'b0;
        stack_err_d = stack_err_q;
`endif
        unique case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                next_addr_d = next_addr_q + ADDR_W'(1);
                state_d     = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (!bus.stall) begin
                    retire = 1'b1;
                    if (bus.halt_req) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
`ifdef FETCH_CALL_STACK_EN
                        // Stack over/underflow degrades to a plain retire and flags the error.
                        if (bus.call_req) begin
                            if (stk_full) stack_err_d = 1'b1;
                            else begin
                                push        = 1'b1;
                                next_addr_d = bus.br_target;
                            end
                        end else if (bus.ret_req) begin
                            if (stk_empty) stack_err_d = 1'b1;
                            else begin
                                pop         = 1'b1;
                                next_addr_d = stk_top;
                            end
                        end else
`endif
                        if (bus.br_req) next_addr_d = bus.br_target;
                    end
                end
            end
            S_HALT:   if (bus.run && !bus.halt_req) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
        retired_d = (retire && (retired_q != '1)) ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        bus.ir_load   = (state_q == S_FETCH);
        bus.pc_branch = (state_q != S_FETCH);
        bus.pc_target = next_addr_q;
        bus.halted    = (state_q == S_HALT);
        bus.state     = (state_q == S_HALT) ? 2'b00 : state_q[1:0];
        bus.retired   = retired_q;
`ifdef FETCH_CALL_STACK_EN
        bus.stack_err = stack_err_q;
`endif
    end

endmodule
